// File: rtl/sc_io_unit.sv
// sc_io_unit: memory-mapped board I/O for the single-cycle computer.
// Owns switch/key synchronisers, key debounce with sticky press capture,
// the LED and hex-digit registers, seven-segment decode and a cycle timer.
// Reads are combinational so a single-cycle lw completes in its own cycle.
module sc_io_unit #(
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int          DEB_CYCLES = 50000,
  parameter int          CNT_W      = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        io_sel,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  led,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [9:0]       r_swMeta, r_swSync;
  logic [3:0]       r_keyMeta, r_keySync;
  logic [3:0]       r_keyStable, r_keyEdge;
  logic [CNT_W-1:0] r_debCnt [4];
  logic [9:0]       r_led;
  logic [4:0]       r_hex [6];
  logic [31:0]      r_timer;

  logic [5:0]       w_word;
  logic             w_wrEn, w_wrEdge, w_wrLed, w_wrTimer;
  logic [3:0]       w_stableNext, w_keyRise, w_edgeClr;
  logic [CNT_W-1:0] w_cntNext [4];

  // Word offset inside the window; byte lanes are ignored (word access only).
  assign w_word    = addr[7:2];
  assign io_sel    = (addr[31:8] == IO_BASE[31:8]);
  assign w_wrEn    = we & io_sel;
  assign w_wrEdge  = w_wrEn & (w_word == 6'h02);
  assign w_wrLed   = w_wrEn & (w_word == 6'h03);
  assign w_wrTimer = w_wrEn & (w_word == 6'h0A);
  assign w_edgeClr = w_wrEdge ? wdata[3:0] : 4'b0000;
  assign w_keyRise = w_stableNext & ~r_keyStable;
  assign led       = r_led;

  // Active-low glyph lookup; bit 4 of a hex register blanks the digit.
  function automatic logic [6:0] seg7(input logic [4:0] h);
    logic [6:0] s;
    s = 7'h7F;
    if (!h[4]) begin
      case (h[3:0])
        4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
        4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
        4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
        4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  // Seven-segment drive straight from the hex registers.
  always_comb begin
    hex0 = seg7(r_hex[0]);
    hex1 = seg7(r_hex[1]);
    hex2 = seg7(r_hex[2]);
    hex3 = seg7(r_hex[3]);
    hex4 = seg7(r_hex[4]);
    hex5 = seg7(r_hex[5]);
  end

  // Debounce decision: count while the sample disagrees, adopt it on the last count.
  always_comb begin
    w_stableNext = r_keyStable;
    for (int i = 0; i < 4; i++) begin
      w_cntNext[i] = '0;
      if (r_keySync[i] != r_keyStable[i]) begin
        if (r_debCnt[i] == DEB_LAST) w_stableNext[i] = r_keySync[i];
        else                         w_cntNext[i]    = r_debCnt[i] + CNT_W'(1);
      end
    end
  end

  // Synchronisers, debounce state and sticky edge capture (a new press beats a clear).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_swMeta    <= '0;
      r_swSync    <= '0;
      r_keyMeta   <= '0;
      r_keySync   <= '0;
      r_keyStable <= '0;
      r_keyEdge   <= '0;
      for (int i = 0; i < 4; i++) r_debCnt[i] <= '0;
    end else begin
      r_swMeta    <= sw;
      r_swSync    <= r_swMeta;
      r_keyMeta   <= ~key;
      r_keySync   <= r_keyMeta;
      r_keyStable <= w_stableNext;
      r_keyEdge   <= (r_keyEdge & ~w_edgeClr) | w_keyRise;
      for (int i = 0; i < 4; i++) r_debCnt[i] <= w_cntNext[i];
    end
  end

  // CPU-writable registers: LED, hex digits and the timer (a store beats the increment).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_led   <= '0;
      r_timer <= '0;
      for (int k = 0; k < 6; k++) r_hex[k] <= 5'h10;
    end else begin
      if (w_wrLed) r_led <= wdata[9:0];
      r_timer <= w_wrTimer ? wdata : r_timer + 32'd1;
      for (int k = 0; k < 6; k++) begin
        if (w_wrEn && (w_word == 6'(4 + k))) r_hex[k] <= wdata[4:0];
      end
    end
  end

  // Combinational read mux; anything unmapped or outside the window reads 0.
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      case (w_word)
        6'h00:   rdata = {22'b0, r_swSync};
        6'h01:   rdata = {28'b0, r_keyStable};
        6'h02:   rdata = {28'b0, r_keyEdge};
        6'h03:   rdata = {22'b0, r_led};
        6'h04:   rdata = {27'b0, r_hex[0]};
        6'h05:   rdata = {27'b0, r_hex[1]};
        6'h06:   rdata = {27'b0, r_hex[2]};
        6'h07:   rdata = {27'b0, r_hex[3]};
        6'h08:   rdata = {27'b0, r_hex[4]};
        6'h09:   rdata = {27'b0, r_hex[5]};
        6'h0A:   rdata = r_timer;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_io_unit.sv
// tb_sc_io_unit: directed and randomized checks of sc_io_unit against a
// behavioural model of the register map, debounce and timer rules.
module tb_sc_io_unit;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr, wdata;
  logic        we;
  logic [31:0] rdata;
  logic        io_sel;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  led;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [9:0]  mLed;
  logic [4:0]  mHex [6];
  logic [31:0] mTimer;
  logic [3:0]  mStable, mEdge;
  logic [9:0]  swHist  [$];
  logic [3:0]  keyHist [$];
  logic [3:0]  debHist [$];
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sc_io_unit #(.IO_BASE(32'hFFFF_FF00), .DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .io_sel(io_sel), .sw(sw), .key(key), .led(led),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #10 clock = ~clock;

  // Predict what the coming rising edge does with the inputs now applied.
  task automatic modelEdge();
    logic [3:0] samp, newStable, clr;
    logic       hit, allDiff;
    if (!resetn) begin
      mLed = '0; mTimer = '0; mStable = '0; mEdge = '0;
      for (int k = 0; k < 6; k++) mHex[k] = 5'h10;
      swHist.delete();  repeat (2) swHist.push_front(10'h0);
      keyHist.delete(); repeat (2) keyHist.push_front(4'h0);
      debHist.delete(); repeat (DEB) debHist.push_front(4'h0);
    end else begin
      samp = keyHist[1];
      debHist.push_front(samp);
      if (debHist.size() > DEB) void'(debHist.pop_back());
      newStable = mStable;
      for (int i = 0; i < 4; i++) begin
        allDiff = 1'b1;
        for (int j = 0; j < DEB; j++) if (debHist[j][i] == mStable[i]) allDiff = 1'b0;
        if (allDiff) newStable[i] = samp[i];
      end
      hit = we && (addr[31:8] == 24'hFFFFFF);
      clr = (hit && addr[7:2] == 6'd2) ? wdata[3:0] : 4'h0;
      mEdge   = (mEdge & ~clr) | (newStable & ~mStable);
      mStable = newStable;
      if (hit && addr[7:2] == 6'd3) mLed = wdata[9:0];
      for (int k = 0; k < 6; k++) if (hit && addr[7:2] == 6'(4 + k)) mHex[k] = wdata[4:0];
      mTimer = (hit && addr[7:2] == 6'd10) ? wdata : mTimer + 32'd1;
      swHist.push_front(sw);    void'(swHist.pop_back());
      keyHist.push_front(~key); void'(keyHist.pop_back());
    end
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    if (a[31:8] != 24'hFFFFFF) return 32'h0;
    case (a[7:2])
      6'd0:  return {22'b0, swHist[1]};
      6'd1:  return {28'b0, mStable};
      6'd2:  return {28'b0, mEdge};
      6'd3:  return {22'b0, mLed};
      6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: return {27'b0, mHex[a[7:2] - 6'd4]};
      6'd10: return mTimer;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [6:0] expHex(input int k);
    return mHex[k][4] ? 7'h7F : glyph[mHex[k][3:0]];
  endfunction

  task automatic tick();
    modelEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic readAt(input logic [31:0] a, output logic [31:0] d);
    we = 1'b0; addr = a; #1; d = rdata;
  endtask

  task automatic checkRead(input string tag, input logic [31:0] a);
    logic [31:0] d;
    readAt(a, d);
    checkOutput(tag, d, expRead(a));
    checkOutput({tag, "_iosel"}, {31'b0, io_sel}, {31'b0, a[31:8] == 24'hFFFFFF});
  endtask

  task automatic checkPins(input string tag);
    checkOutput({tag, "_led"},  {22'b0, led},  {22'b0, mLed});
    checkOutput({tag, "_hex0"}, {25'b0, hex0}, {25'b0, expHex(0)});
    checkOutput({tag, "_hex1"}, {25'b0, hex1}, {25'b0, expHex(1)});
    checkOutput({tag, "_hex2"}, {25'b0, hex2}, {25'b0, expHex(2)});
    checkOutput({tag, "_hex3"}, {25'b0, hex3}, {25'b0, expHex(3)});
    checkOutput({tag, "_hex4"}, {25'b0, hex4}, {25'b0, expHex(4)});
    checkOutput({tag, "_hex5"}, {25'b0, hex5}, {25'b0, expHex(5)});
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] d, ra;
    resetn = 1'b0; addr = '0; wdata = '0; we = 1'b0; sw = '0; key = 4'hF;

    // Reset for two cycles, then check the cleared state before any further edge.
    tick(); tick();
    resetn = 1'b1;
    checkOutput("rst_led",  {22'b0, led},  32'h0);
    checkOutput("rst_hex0", {25'b0, hex0}, 32'h7F);
    checkOutput("rst_hex3", {25'b0, hex3}, 32'h7F);
    checkOutput("rst_hex5", {25'b0, hex5}, 32'h7F);
    readAt(32'hFFFFFF04, d); checkOutput("rst_key",   d, 32'h0);
    readAt(32'hFFFFFF08, d); checkOutput("rst_edge",  d, 32'h0);
    readAt(32'hFFFFFF0C, d); checkOutput("rst_ledrd", d, 32'h0);
    readAt(32'hFFFFFF28, d); checkOutput("rst_timer", d, 32'h0);
    tick();
    readAt(32'hFFFFFF28, d); checkOutput("timer_first", d, 32'h1);

    // Register writes and readback; a store outside the window changes nothing.
    applyStimulus(32'hFFFFFF10, 32'h3);
    applyStimulus(32'hFFFFFF24, 32'h1E);
    applyStimulus(32'hFFFFFF0C, 32'h2AA);
    checkOutput("wr_hex0", {25'b0, hex0}, 32'h30);
    checkOutput("wr_hex5", {25'b0, hex5}, 32'h7F);
    checkOutput("wr_led",  {22'b0, led},  32'h2AA);
    readAt(32'hFFFFFF10, d); checkOutput("rd_hex0", d, 32'h3);
    readAt(32'hFFFFFF24, d); checkOutput("rd_hex5", d, 32'h1E);
    readAt(32'hFFFFFF0C, d); checkOutput("rd_led",  d, 32'h2AA);
    addr = 32'h00000010; wdata = 32'h5; we = 1'b1; #1;
    checkOutput("out_iosel", {31'b0, io_sel}, 32'h0);
    tick(); we = 1'b0;
    checkOutput("out_hex0", {25'b0, hex0}, 32'h30);
    checkPins("out");

    // Short bounce on key 2 must not register.
    key = 4'hB; tick(); tick(); key = 4'hF;
    for (int n = 0; n < 6; n++) begin
      tick(); readAt(32'hFFFFFF04, d); checkOutput("bounce_key", d, 32'h0);
    end
    // Held press registers after DEB+2 cycles and sets the sticky edge.
    key = 4'hB;
    for (int n = 0; n < DEB + 1; n++) tick();
    readAt(32'hFFFFFF04, d); checkOutput("press_early", d, 32'h0);
    tick();
    readAt(32'hFFFFFF04, d); checkOutput("press_key",  d, 32'h4);
    readAt(32'hFFFFFF08, d); checkOutput("press_edge", d, 32'h4);
    for (int n = 0; n < 4; n++) tick();
    key = 4'hF;
    for (int n = 0; n < DEB + 3; n++) tick();
    readAt(32'hFFFFFF04, d); checkOutput("release_key",  d, 32'h0);
    readAt(32'hFFFFFF08, d); checkOutput("release_edge", d, 32'h4);

    // Clear all edges in the very cycle key 0 becomes stable: the new press wins.
    key = 4'hE;
    for (int n = 0; n < DEB + 1; n++) tick();
    readAt(32'hFFFFFF04, d); checkOutput("race_pre", d, 32'h0);
    applyStimulus(32'hFFFFFF08, 32'hF);
    readAt(32'hFFFFFF08, d); checkOutput("race_edge", d, 32'h1);
    readAt(32'hFFFFFF04, d); checkOutput("race_key",  d, 32'h1);
    key = 4'hF;
    for (int n = 0; n < DEB + 3; n++) tick();

    // Reset in the middle of a press discards progress; the press needs the full time again.
    key = 4'hD; tick(); tick(); tick();
    resetn = 1'b0; tick(); resetn = 1'b1;
    for (int n = 0; n < DEB + 1; n++) tick();
    readAt(32'hFFFFFF04, d); checkOutput("rstpress_early", d, 32'h0);
    tick();
    readAt(32'hFFFFFF04, d); checkOutput("rstpress_key",  d, 32'h2);
    readAt(32'hFFFFFF08, d); checkOutput("rstpress_edge", d, 32'h2);
    key = 4'hF;

    // Timer load and wrap.
    applyStimulus(32'hFFFFFF28, 32'hFFFFFFFE);
    readAt(32'hFFFFFF28, d); checkOutput("timer_load", d, 32'hFFFFFFFE);
    tick();
    readAt(32'hFFFFFF28, d); checkOutput("timer_max",  d, 32'hFFFFFFFF);
    tick();
    readAt(32'hFFFFFF28, d); checkOutput("timer_wrap", d, 32'h0);

    // Switch synchroniser latency and unmapped offsets.
    sw = 10'h155;
    tick();
    readAt(32'hFFFFFF00, d); checkOutput("sw_lag1", d, 32'h0);
    tick();
    readAt(32'hFFFFFF00, d); checkOutput("sw_sync", d, 32'h155);
    readAt(32'hFFFFFF2C, d); checkOutput("unmapped_2c", d, 32'h0);
    readAt(32'hFFFFFFFC, d); checkOutput("unmapped_fc", d, 32'h0);
    addr = 32'hFFFFFE00; #1;
    checkOutput("iosel_below", {31'b0, io_sel}, 32'h0);
    addr = 32'hFFFFFF00; #1;
    checkOutput("iosel_base",  {31'b0, io_sel}, 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      checkPins("rnd");
      if ($urandom_range(0, 7) == 0) ra = $urandom;
      else ra = {24'hFFFFFF, 6'($urandom_range(0, 12)), 2'($urandom_range(0, 3))};
      checkRead("rnd_rd", ra);
      resetn = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 5) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) sw = 10'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      addr  = ($urandom_range(0, 9) == 0) ? $urandom
                                          : {24'hFFFFFF, 6'($urandom_range(0, 11)), 2'b00};
      wdata = $urandom;
      tick();
      we = 1'b0;
    end
    resetn = 1'b1;
    checkPins("final");
    checkRead("final_key",  32'hFFFFFF04);
    checkRead("final_edge", 32'hFFFFFF08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
